led_mmio_ctrl: RTL and testbench
================================

// Module: led_mmio_ctrl
// PURPOSE
// - Memory-mapped LED peripheral between core data bus and zedboard led[7:0] pins.
// - Core stores set static pattern, per-bit blink mask and blink period; block drives led_o.
// - Gives core programs a visible result on board and a waveform-checkable result in sim.
// PARAMETERS
// - ADDR_WIDTH   5          byte-offset width inside peripheral window; bits [1:0] ignored
// - DATA_WIDTH   32         bus data width
// - LED_WIDTH    8          number of LED outputs (<= DATA_WIDTH)
// - DIV_WIDTH    24         blink prescaler width
// - DIV_RESET    24'd62_500 BLINK_PERIOD reset value (0.5 ms half-period at 125 MHz)
// PORTS
// - clk        in   1            system clock, rising edge
// - rst        in   1            async active-high reset
// - bus_addr   in   ADDR_WIDTH   byte offset
// - bus_wdata  in   DATA_WIDTH   write data
// - bus_we     in   1            write strobe, one-cycle pulse per access
// - bus_re     in   1            read strobe, one-cycle pulse per access
// - bus_rdata  out  DATA_WIDTH   read data, valid while bus_ready=1
// - bus_ready  out  1            access-complete pulse
// - led_o      out  LED_WIDTH    LED drive, 1 = on
// BEHAVIOUR
// - Reset (async assert, sync release): LED_OUT=0, BLINK_MASK=0, BLINK_PERIOD=DIV_RESET,
//   prescaler=DIV_RESET, phase=1, tick_cnt=0, bus_rdata=0, bus_ready=0, led_o=0.
// - Register map (offset): 0x00 LED_OUT rw [LED_WIDTH-1:0]; 0x04 BLINK_MASK rw;
//   0x08 BLINK_PERIOD rw [DIV_WIDTH-1:0]; 0x0C STATUS ro {tick_cnt[15:0], 15'b0, phase};
//   0x10 BRIGHT (LED_PWM_EN only). Unused upper bits read 0, ignore writes.
// - Handshake: strobe sampled at cycle N; register updated and bus_ready=1 at N+1,
//   for exactly one cycle; bus_rdata valid at N+1, 0 in all other cycles.
// - we and re same cycle: write performed, read ignored, bus_rdata=0, one bus_ready pulse.
// - Strobe at N+1 while bus_ready high: accepted normally (back-to-back, 1 access/cycle).
// - Unmapped offset: write dropped, read returns 0, bus_ready still pulses.
// - Prescaler: down-counter; at 0 and BLINK_PERIOD!=0: reload BLINK_PERIOD, toggle phase,
//   tick_cnt+1 (16-bit, wraps 0xFFFF->0x0000). Half-period = BLINK_PERIOD+1 cycles.
// - BLINK_PERIOD=0: blinking stopped, phase forced 1, prescaler held 0, tick_cnt frozen.
// - Write to BLINK_PERIOD: prescaler loads new value, phase forced 1 in the same edge.
// - led_o registered: led_o = LED_OUT & ~(BLINK_MASK & {LED_WIDTH{~phase}}) [& pwm_on];
//   register write at N visible on led_o at N+2.
// - rst asserted mid-access: bus_ready/bus_rdata drop at once, access lost, no retry.
// CONFIGURATION
// - LED_PWM_EN defined: BRIGHT reg 0x10 [7:0], reset 8'hFF; free-running 8-bit pwm_cnt;
//   pwm_on = (pwm_cnt < BRIGHT) | (BRIGHT==8'hFF); BRIGHT=0 keeps led_o at 0.
// - LED_PWM_EN undefined: no BRIGHT reg, 0x10 unmapped (reads 0), pwm_on term absent.
// TESTING
// - Reset release: led_o=0, STATUS read = 32'h0000_0001, BLINK_PERIOD read = 62_500.
// - Write LED_OUT=0xA5 at cycle N -> bus_ready=1 at N+1, led_o=0xA5 at N+2; read back 0xA5.
// - BLINK_PERIOD=3, BLINK_MASK=0x0F, LED_OUT=0xFF -> led_o alternates 0xFF/0xF0 every 4
//   cycles; STATUS[31:16] increments per toggle.
// - BLINK_PERIOD=0 while phase=0 -> phase=1, led_o=LED_OUT steadily, tick_cnt frozen.
// - we+re same cycle to 0x00 (wdata 0x3C) -> LED_OUT=0x3C, bus_rdata=0, one ready pulse;
//   read 0x14 -> 0, ready pulses.
// - LED_PWM_EN: BRIGHT=0x40, LED_OUT=0x01 -> led_o[0] high 64 of every 256 cycles.

Source files
------------

// File: rtl/led_mmio_ctrl.sv
// LED MMIO peripheral: static pattern, per-bit blink mask and blink prescaler driving led_o.
// Optional brightness PWM (BRIGHT at 0x10) is built in when LED_PWM_EN is defined.
module led_mmio_ctrl #(
  parameter int unsigned          ADDR_WIDTH = 5,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          LED_WIDTH  = 8,
  parameter int unsigned          DIV_WIDTH  = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(62_500)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_we,
  input  logic                  bus_re,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_ready,
  output logic [LED_WIDTH-1:0]  led_o
);

  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - 2;
  localparam int unsigned TICK_WIDTH = 16;
  localparam int unsigned STAT_PAD   = 15;
  localparam int unsigned PWM_WIDTH  = 8;

  localparam logic [IDX_WIDTH-1:0] IDX_LED_OUT = IDX_WIDTH'(0);
  localparam logic [IDX_WIDTH-1:0] IDX_MASK    = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_PERIOD  = IDX_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] IDX_STATUS  = IDX_WIDTH'(3);
`ifdef LED_PWM_EN
  localparam logic [IDX_WIDTH-1:0] IDX_BRIGHT  = IDX_WIDTH'(4);
`endif

  logic [LED_WIDTH-1:0]  r_led_out;
  logic [LED_WIDTH-1:0]  r_blink_mask;
  logic [DIV_WIDTH-1:0]  r_period;
  logic [DIV_WIDTH-1:0]  r_presc;
  logic                  r_phase;
  logic [TICK_WIDTH-1:0] r_tick_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic [LED_WIDTH-1:0]  r_led_o;

  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_rd;
  logic                  w_wr_led;
  logic                  w_wr_mask;
  logic                  w_wr_period;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_pwm_on;
  logic                  w_unused;

  // Word index; byte-lane bits are ignored. A simultaneous write wins over the read.
  assign w_idx       = bus_addr[ADDR_WIDTH-1:2];
  assign w_rd        = bus_re & ~bus_we;
  assign w_wr_led    = bus_we && (w_idx == IDX_LED_OUT);
  assign w_wr_mask   = bus_we && (w_idx == IDX_MASK);
  assign w_wr_period = bus_we && (w_idx == IDX_PERIOD);
  assign w_unused    = ^{bus_addr[1:0], bus_wdata[DATA_WIDTH-1:DIV_WIDTH]};

`ifdef LED_PWM_EN
  logic [PWM_WIDTH-1:0] r_bright;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic                 w_wr_bright;

  assign w_wr_bright = bus_we && (w_idx == IDX_BRIGHT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright  <= '1;
      r_pwm_cnt <= '0;
    end else begin
      if (w_wr_bright) r_bright <= bus_wdata[PWM_WIDTH-1:0];
      r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
    end
  end

  // Full scale is always on so BRIGHT=0xFF means no dimming at all.
  assign w_pwm_on = (r_pwm_cnt < r_bright) || (r_bright == '1);
`else
  assign w_pwm_on = 1'b1;
`endif

  // Read mux over current register contents; unmapped offsets read zero.
  always_comb begin
    w_rd_val = '0;
    case (w_idx)
      IDX_LED_OUT: w_rd_val = DATA_WIDTH'(r_led_out);
      IDX_MASK:    w_rd_val = DATA_WIDTH'(r_blink_mask);
      IDX_PERIOD:  w_rd_val = DATA_WIDTH'(r_period);
      IDX_STATUS:  w_rd_val = DATA_WIDTH'({r_tick_cnt, STAT_PAD'(0), r_phase});
`ifdef LED_PWM_EN
      IDX_BRIGHT:  w_rd_val = DATA_WIDTH'(r_bright);
`endif
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= bus_we | bus_re;
      r_rdata <= w_rd ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_out    <= '0;
      r_blink_mask <= '0;
    end else begin
      if (w_wr_led)  r_led_out    <= bus_wdata[LED_WIDTH-1:0];
      if (w_wr_mask) r_blink_mask <= bus_wdata[LED_WIDTH-1:0];
    end
  end

  // Blink prescaler: a period write restarts the half-period in the lit phase;
  // period 0 parks the blinker lit with the tick counter frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period   <= DIV_RESET;
      r_presc    <= DIV_RESET;
      r_phase    <= 1'b1;
      r_tick_cnt <= '0;
    end else if (w_wr_period) begin
      r_period <= bus_wdata[DIV_WIDTH-1:0];
      r_presc  <= bus_wdata[DIV_WIDTH-1:0];
      r_phase  <= 1'b1;
    end else if (r_period == '0) begin
      r_presc <= '0;
      r_phase <= 1'b1;
    end else if (r_presc == '0) begin
      r_presc    <= r_period;
      r_phase    <= ~r_phase;
      r_tick_cnt <= r_tick_cnt + TICK_WIDTH'(1);
    end else begin
      r_presc <= r_presc - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_led_o <= '0;
    else     r_led_o <= r_led_out & ~(r_blink_mask & {LED_WIDTH{~r_phase}})
                        & {LED_WIDTH{w_pwm_on}};
  end

  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;
  assign led_o     = r_led_o;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Bench for led_mmio_ctrl: directed scenarios plus random bus traffic checked every cycle
// against a closed-form model (blink phase and tick count derived from elapsed cycles).
module tb_led_mmio_ctrl;

  localparam logic [23:0] DIV_RST = 24'd62_500;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  led_o;

  led_mmio_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .led_o     (led_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: registers plus the edge at which the blinker last restarted.
  int unsigned ecnt;
  logic [7:0]  m_led;
  logic [7:0]  m_mask;
  logic [23:0] m_period;
  int unsigned m_anchor;
  logic [15:0] m_tbase;
  logic [7:0]  m_bright;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, act, exp, ecnt);
  endtask

  task automatic model_reset();
    ecnt     = 0;
    m_led    = 8'h00;
    m_mask   = 8'h00;
    m_period = DIV_RST;
    m_anchor = 0;
    m_tbase  = 16'h0000;
    m_bright = 8'hFF;
  endtask

  // Toggles since restart: one every period+1 cycles, none when stopped.
  function automatic int unsigned toggles(input int unsigned t);
    if (m_period == 24'd0) return 0;
    return (t - m_anchor) / ({8'd0, m_period} + 32'd1);
  endfunction

  function automatic logic phase_at(input int unsigned t);
    int unsigned n;
    n = toggles(t);
    return (n % 2) == 0;
  endfunction

  function automatic logic [15:0] tick_at(input int unsigned t);
    return m_tbase + 16'(toggles(t));
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a, input int unsigned t);
    logic [2:0] idx;
    idx = a[4:2];
    case (idx)
      3'd0: return {24'd0, m_led};
      3'd1: return {24'd0, m_mask};
      3'd2: return {8'd0, m_period};
      3'd3: return {tick_at(t), 15'd0, phase_at(t)};
`ifdef LED_PWM_EN
      3'd4: return {24'd0, m_bright};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, clock, update model, check all outputs 1 time unit later.
  task automatic bus_cycle(input logic we, input logic re, input logic [4:0] a,
                           input logic [31:0] d);
    int unsigned t0;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
    logic        ph;
    logic [2:0]  idx;
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    t0 = ecnt;
    ecnt++;
    exp_rd  = (re && !we) ? rd_model(a, t0) : 32'd0;
    ph      = phase_at(t0);
    exp_led = m_led & ~(m_mask & {8{~ph}});
`ifdef LED_PWM_EN
    if (!((8'(t0) < m_bright) || (m_bright == 8'hFF))) exp_led = 8'h00;
`endif
    idx = a[4:2];
    if (we) begin
      case (idx)
        3'd0: m_led  = d[7:0];
        3'd1: m_mask = d[7:0];
        3'd2: begin
          m_tbase  = tick_at(t0);
          m_anchor = ecnt;
          m_period = d[23:0];
        end
`ifdef LED_PWM_EN
        3'd4: m_bright = d[7:0];
`endif
        default: ;
      endcase
    end
    #1;
    check_eq("ready", {31'd0, bus_ready}, {31'd0, we | re});
    check_eq("rdata", bus_rdata, exp_rd);
    check_eq("led",   {24'd0, led_o}, {24'd0, exp_led});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 5'h00, 32'd0);
  endtask

  initial begin
    int          cnt_ff, cnt_f0, cnt_on;
    logic        found;
    logic        we, re;
    logic [4:0]  a;
    logic [31:0] d;

    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 5'h00; bus_wdata = 32'd0;
    rst = 1'b1;
    model_reset();
    #22;
    check_eq("rst_ready", {31'd0, bus_ready}, 32'd0);
    check_eq("rst_rdata", bus_rdata, 32'd0);
    check_eq("rst_led",   {24'd0, led_o}, 32'd0);
    rst = 1'b0;

    // Reset values visible through the bus
    bus_cycle(1'b0, 1'b1, 5'h0C, 32'd0);
    check_eq("status_rst", bus_rdata, 32'h0000_0001);
    bus_cycle(1'b0, 1'b1, 5'h08, 32'd0);
    check_eq("period_rst", bus_rdata, 32'd62_500);

    // Write latency: ready at N+1, led_o at N+2
    bus_cycle(1'b1, 1'b0, 5'h00, 32'hFFFF_FFA5);
    check_eq("a5_ready", {31'd0, bus_ready}, 32'd1);
    check_eq("a5_led_n1", {24'd0, led_o}, 32'd0);
    idle(1);
    check_eq("a5_led_n2", {24'd0, led_o}, 32'h0000_00A5);
    check_eq("a5_ready_drop", {31'd0, bus_ready}, 32'd0);
    bus_cycle(1'b0, 1'b1, 5'h01, 32'd0);
    check_eq("a5_readback", bus_rdata, 32'h0000_00A5);

    // Blink: period 3, mask 0x0F, pattern 0xFF -> 0xFF/0xF0 every 4 cycles
    bus_cycle(1'b1, 1'b0, 5'h04, 32'h0000_000F);
    bus_cycle(1'b1, 1'b0, 5'h00, 32'h0000_00FF);
    bus_cycle(1'b1, 1'b0, 5'h08, 32'h0000_0003);
    idle(2);
    cnt_ff = 0; cnt_f0 = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (led_o == 8'hFF) cnt_ff++;
      if (led_o == 8'hF0) cnt_f0++;
    end
    check_eq("blink_ff_cnt", 32'(cnt_ff), 32'd8);
    check_eq("blink_f0_cnt", 32'(cnt_f0), 32'd8);

    // Stop blinking while in the dark phase
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (!phase_at(ecnt)) found = 1'b1;
      else idle(1);
    end
    check_eq("ph0_found", {31'd0, found}, 32'd1);
    bus_cycle(1'b1, 1'b0, 5'h08, 32'd0);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check_eq("stopped_led", {24'd0, led_o}, 32'h0000_00FF);
    end
    bus_cycle(1'b0, 1'b1, 5'h0C, 32'd0);
    check_eq("stopped_status", bus_rdata, {m_tbase, 15'd0, 1'b1});

    // Write and read together, then an unmapped read
    bus_cycle(1'b1, 1'b1, 5'h00, 32'h0000_003C);
    check_eq("wr_rd_rdata", bus_rdata, 32'd0);
    check_eq("wr_rd_ready", {31'd0, bus_ready}, 32'd1);
    bus_cycle(1'b0, 1'b1, 5'h00, 32'd0);
    check_eq("wr_rd_led_out", bus_rdata, 32'h0000_003C);
    bus_cycle(1'b0, 1'b1, 5'h14, 32'd0);
    check_eq("unmapped_rd", bus_rdata, 32'd0);
    check_eq("unmapped_ready", {31'd0, bus_ready}, 32'd1);
`ifndef LED_PWM_EN
    bus_cycle(1'b1, 1'b0, 5'h10, 32'hFFFF_FFFF);
    bus_cycle(1'b0, 1'b1, 5'h10, 32'd0);
    check_eq("no_bright", bus_rdata, 32'd0);
`endif

    // Random traffic, short blink periods so toggles are frequent
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) == 0);
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      if (a[4:2] == 3'd2) d[23:0] = 24'($urandom_range(0, 6));
      bus_cycle(we, re, a, d);
    end

`ifdef LED_PWM_EN
    // Brightness 0x40 -> led_o[0] lit 64 of every 256 cycles
    bus_cycle(1'b1, 1'b0, 5'h04, 32'd0);
    bus_cycle(1'b1, 1'b0, 5'h00, 32'h0000_0001);
    bus_cycle(1'b1, 1'b0, 5'h10, 32'h0000_0040);
    idle(2);
    cnt_on = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (led_o[0]) cnt_on++;
    end
    check_eq("pwm_on_cnt", 32'(cnt_on), 32'd64);
    bus_cycle(1'b1, 1'b0, 5'h10, 32'd0);
    idle(2);
    cnt_on = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (led_o != 8'h00) cnt_on++;
    end
    check_eq("pwm_off_cnt", 32'(cnt_on), 32'd0);
`endif

    // Reset in the middle of a completing read
    bus_cycle(1'b1, 1'b0, 5'h00, 32'h0000_00FF);
    bus_cycle(1'b0, 1'b1, 5'h0C, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, bus_ready}, 32'd0);
    check_eq("midrst_rdata", bus_rdata, 32'd0);
    check_eq("midrst_led",   {24'd0, led_o}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    bus_cycle(1'b0, 1'b1, 5'h08, 32'd0);
    check_eq("period_rst2", bus_rdata, 32'd62_500);
    bus_cycle(1'b0, 1'b1, 5'h00, 32'd0);
    check_eq("led_out_rst2", bus_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
